// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch front end: exception causes,
// default constants, the fetch queue entry layout and the fetch FSM states.
package fetch_stage_pkg;

    localparam logic [3:0]  EXC_INSTR_MISALIGNED   = 4'd0;
    localparam logic [3:0]  EXC_INSTR_ACCESS_FAULT = 4'd1;

    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
    localparam logic [63:0] RESET_PC_DEF  = 64'h0;

    // One fetched instruction (or fetch exception) as held in the queue.
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        exc_en;
        logic [3:0]  exc_code;
        logic [63:0] exc_val;
    } fetch_entry_t;

    localparam int unsigned FETCH_ENTRY_W = $bits(fetch_entry_t);

    typedef enum logic {
        ST_RUN           = 1'b0,
        ST_WAIT_REDIRECT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Generic DEPTH-entry synchronous FIFO with flush. A full queue accepts a push
// in the same cycle it pops. Head data is read combinationally from storage.
//   clk, rst    : clock, synchronous active-high reset
//   flush       : drop all entries (takes priority over push/pop)
//   push, data  : write push_data at the tail
//   pop         : consume the head entry
//   head_data   : current head entry (meaningful only when count != 0)
//   count       : number of valid entries, 0..DEPTH
module fetch_queue #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_pop;

    assign do_pop    = pop && (count != '0);
    assign head_data = mem[rd_ptr];

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !do_pop)      count <= count + CNT_W'(1);
            else if (!push && do_pop) count <= count - CNT_W'(1);
        end
    end

    // Storage; when full, wr_ptr == rd_ptr and the head is overwritten only
    // as it is popped in the same cycle.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_stage.sv
// RV64 instruction fetch front end. Holds the architectural PC, presents it to
// the combinational instruction memory, captures the result (or a fetch
// exception) into an in-order queue and hands entries to decode.
//   clk, rst                     : clock, synchronous active-high reset
//   pc_addr                      : fetch address (the PC register)
//   imem_instr / imem_exc_*      : instruction memory response for pc_addr
//   redirect_valid, redirect_pc  : PC change from later stages, flushes queue
//   out_valid, out_ready         : handshake to decode
//   out_pc/instr/exc_*           : head-of-queue entry fields
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = RESET_PC_DEF,
    parameter int unsigned DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    output logic [63:0] pc_addr,
    input  logic [31:0] imem_instr,
    input  logic        imem_exc_en,
    input  logic [3:0]  imem_exc_code,
    input  logic [63:0] imem_exc_val,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_exc_en,
    output logic [3:0]  out_exc_code,
    output logic [63:0] out_exc_val
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    fetch_state_t     state_q, state_d;
    logic [63:0]      pc_q, pc_d;
    logic [CNT_W-1:0] count;
    logic             pop, room, push;
    fetch_entry_t     cap, head;

    assign pc_addr   = pc_q;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign room      = (count < CNT_W'(DEPTH)) || pop;
    assign push      = (state_q == ST_RUN) && room && !redirect_valid;

    // Capture mux: misalignment outranks a memory fault.
    always_comb begin
        cap          = '0;
        cap.pc       = pc_q;
        cap.instr    = imem_instr;
        if (pc_q[1:0] != 2'b00) begin
            cap.instr    = NOP_INSTR;
            cap.exc_en   = 1'b1;
            cap.exc_code = EXC_INSTR_MISALIGNED;
            cap.exc_val  = pc_q;
        end else if (imem_exc_en) begin
            cap.instr    = NOP_INSTR;
            cap.exc_en   = 1'b1;
            cap.exc_code = imem_exc_code;
            cap.exc_val  = imem_exc_val;
        end
    end

    fetch_queue #(
        .WIDTH (FETCH_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (cap),
        .pop       (pop),
        .head_data (head),
        .count     (count)
    );

    // State and PC registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next state / next PC; redirect wins, an exception entry halts fetch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (redirect_valid) begin
            state_d = ST_RUN;
            pc_d    = redirect_pc;
        end else if (push) begin
            if (cap.exc_en) state_d = ST_WAIT_REDIRECT;
            else            pc_d    = pc_q + 64'd4;
        end
    end

    // Head fields; an empty queue presents the reset values.
    always_comb begin
        out_pc       = '0;
        out_instr    = NOP_INSTR;
        out_exc_en   = 1'b0;
        out_exc_code = '0;
        out_exc_val  = '0;
        if (out_valid) begin
            out_pc       = head.pc;
            out_instr    = head.instr;
            out_exc_en   = head.exc_en;
            out_exc_code = head.exc_code;
            out_exc_val  = head.exc_val;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, backpressure, access fault,
// redirect flush, misaligned redirect and mid-run reset.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] pc_addr;
    logic [31:0] imem_instr;
    logic        imem_exc_en;
    logic [3:0]  imem_exc_code;
    logic [63:0] imem_exc_val;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_exc_en;
    logic [3:0]  out_exc_code;
    logic [63:0] out_exc_val;

    logic        fault_on;
    logic [63:0] fault_addr;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .pc_addr        (pc_addr),
        .imem_instr     (imem_instr),
        .imem_exc_en    (imem_exc_en),
        .imem_exc_code  (imem_exc_code),
        .imem_exc_val   (imem_exc_val),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_exc_en     (out_exc_en),
        .out_exc_code   (out_exc_code),
        .out_exc_val    (out_exc_val)
    );

    // Instruction memory: two known words at 0 and 4, a tagged word elsewhere.
    always_comb begin
        if (pc_addr == 64'h0)      imem_instr = 32'h0010_0093;
        else if (pc_addr == 64'h4) imem_instr = 32'h0020_0113;
        else                       imem_instr = {16'hDEAD, pc_addr[15:0]};
        imem_exc_en   = fault_on && (pc_addr == fault_addr);
        imem_exc_code = 4'd1;
        imem_exc_val  = pc_addr;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Advance to just after the next rising edge; new inputs are applied
    // here and outputs are sampled one time unit later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        fault_on       = 1'b0;
        fault_addr     = 64'h8_0000;

        // Reset state.
        do_reset();
        settle();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_pc", out_pc, 64'd0);
        check("rst_instr", 64'(out_instr), 64'h13);
        check("rst_exc_en", 64'(out_exc_en), 64'd0);
        check("rst_exc_code", 64'(out_exc_code), 64'd0);
        check("rst_exc_val", out_exc_val, 64'd0);
        check("rst_pc_addr", pc_addr, 64'd0);

        // Streaming with out_ready high.
        out_ready = 1'b1;
        cyc(); settle();
        check("s_pc_addr1", pc_addr, 64'h4);
        check("s_valid1", 64'(out_valid), 64'd1);
        check("s_out_pc1", out_pc, 64'h0);
        check("s_instr1", 64'(out_instr), 64'h0010_0093);
        cyc(); settle();
        check("s_pc_addr2", pc_addr, 64'h8);
        check("s_valid2", 64'(out_valid), 64'd1);
        check("s_out_pc2", out_pc, 64'h4);
        check("s_instr2", 64'(out_instr), 64'h0020_0113);

        // Backpressure: queue fills at two entries and fetch stalls at 8.
        do_reset();
        out_ready = 1'b0;
        settle();
        check("bp_pc_a", pc_addr, 64'h0);
        cyc(); settle();
        check("bp_pc_b", pc_addr, 64'h4);
        check("bp_head_b", out_pc, 64'h0);
        for (int i = 0; i < 3; i++) begin
            cyc(); settle();
            check("bp_pc_hold", pc_addr, 64'h8);
            check("bp_head_hold", out_pc, 64'h0);
            check("bp_instr_hold", 64'(out_instr), 64'h0010_0093);
        end
        out_ready = 1'b1;
        settle();
        check("bp_drain_pc0", out_pc, 64'h0);
        cyc(); settle();
        check("bp_drain_pc4", out_pc, 64'h4);
        check("bp_fetch_c", pc_addr, 64'hC);
        cyc(); settle();
        check("bp_drain_pc8", out_pc, 64'h8);
        check("bp_drain_instr8", 64'(out_instr), 64'hDEAD_0008);
        check("bp_fetch_10", pc_addr, 64'h10);

        // Access fault at 0x80000 halts fetch until a redirect.
        fault_on       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8_0000;
        cyc();
        redirect_valid = 1'b0;
        settle();
        check("af_flush_valid", 64'(out_valid), 64'd0);
        check("af_pc_addr", pc_addr, 64'h8_0000);
        cyc(); settle();
        check("af_valid", 64'(out_valid), 64'd1);
        check("af_out_pc", out_pc, 64'h8_0000);
        check("af_exc_en", 64'(out_exc_en), 64'd1);
        check("af_exc_code", 64'(out_exc_code), 64'd1);
        check("af_exc_val", out_exc_val, 64'h8_0000);
        check("af_instr", 64'(out_instr), 64'h13);
        check("af_pc_hold", pc_addr, 64'h8_0000);
        for (int i = 0; i < 2; i++) begin
            cyc(); settle();
            check("af_no_more", 64'(out_valid), 64'd0);
            check("af_pc_stuck", pc_addr, 64'h8_0000);
        end
        fault_on = 1'b0;

        // Redirect flushes a full queue.
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h200;
        cyc();
        redirect_valid = 1'b0;
        cyc();
        cyc(); settle();
        check("rd_full_valid", 64'(out_valid), 64'd1);
        check("rd_full_head", out_pc, 64'h200);
        check("rd_full_pc", pc_addr, 64'h208);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h100;
        cyc();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        settle();
        check("rd_flushed", 64'(out_valid), 64'd0);
        check("rd_pc_addr", pc_addr, 64'h100);
        cyc(); settle();
        check("rd_new_valid", 64'(out_valid), 64'd1);
        check("rd_new_head", out_pc, 64'h100);

        // Misaligned redirect target.
        redirect_valid = 1'b1;
        redirect_pc    = 64'h102;
        cyc();
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        settle();
        check("ma_pc_addr", pc_addr, 64'h102);
        check("ma_empty", 64'(out_valid), 64'd0);
        cyc(); settle();
        check("ma_valid", 64'(out_valid), 64'd1);
        check("ma_out_pc", out_pc, 64'h102);
        check("ma_exc_en", 64'(out_exc_en), 64'd1);
        check("ma_exc_code", 64'(out_exc_code), 64'd0);
        check("ma_exc_val", out_exc_val, 64'h102);
        check("ma_instr", 64'(out_instr), 64'h13);
        cyc(); settle();
        check("ma_pc_hold", pc_addr, 64'h102);
        check("ma_head_hold", out_pc, 64'h102);

        // Reset while full and waiting for a redirect.
        fault_on       = 1'b1;
        fault_addr     = 64'h304;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h300;
        cyc();
        redirect_valid = 1'b0;
        cyc();
        cyc(); settle();
        check("rs_full_head", out_pc, 64'h300);
        check("rs_wait_pc", pc_addr, 64'h304);
        rst = 1'b1;
        cyc();
        rst       = 1'b0;
        fault_on  = 1'b0;
        out_ready = 1'b1;
        settle();
        check("rs_valid", 64'(out_valid), 64'd0);
        check("rs_pc_addr", pc_addr, 64'h0);
        cyc(); settle();
        check("rs_resume_head", out_pc, 64'h0);
        check("rs_resume_instr", 64'(out_instr), 64'h0010_0093);
        check("rs_resume_pc", pc_addr, 64'h4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch front end for the RV64 core. Owns the architectural PC and drives the combinational instruction memory with it. Captures the returned instruction or fetch exception into a small in-order queue, which feeds decode over a valid/ready handshake. Handles redirects (branch, jump, trap, mret) from later stages by flushing the queue and reloading the PC.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- DEPTH, 2, fetch queue entries; power of two, ≥ 2.
- NOP_INSTR, 32'h00000013, instruction word placed in exception entries and in out_instr when the queue is empty.

Ports:
- clk, in, 1, clock; all state updates on the rising edge.
- rst, in, 1, reset.
- pc_addr, out, 64, fetch address to instruction memory; equals the PC register.
- imem_instr, in, 32, instruction returned combinationally for pc_addr.
- imem_exc_en, in, 1, instruction memory reports an access fault for pc_addr.
- imem_exc_code, in, 4, memory exception cause.
- imem_exc_val, in, 64, memory exception value.
- redirect_valid, in, 1, later stage requests a PC change.
- redirect_pc, in, 64, new fetch PC.
- out_valid, out, 1, queue head valid.
- out_ready, in, 1, decode accepts the head this cycle.
- out_pc, out, 64, PC of the head entry.
- out_instr, out, 32, instruction of the head entry.
- out_exc_en, out, 1, head entry carries a fetch exception.
- out_exc_code, out, 4, cause of the head entry's exception.
- out_exc_val, out, 64, mtval of the head entry's exception.

Behaviour:
- Reset: rst is synchronous, active-high.
  - pc ← RESET_PC; queue count, read pointer and write pointer ← 0; state ← RUN.
  - out_valid = 0, out_pc = 0, out_instr = NOP_INSTR, out_exc_en = 0, out_exc_code = 0, out_exc_val = 0.
  - rst asserted mid-operation discards all queued entries and any pending state.
- States:
  - RUN: fetching.
  - WAIT_REDIRECT: an exception entry has been queued; fetching is halted.
- Defined signals:
  - pop = out_valid && out_ready.
  - room = (count < DEPTH) || pop. A full queue accepts a push in the same cycle it pops.
  - push = (state == RUN) && room && !redirect_valid.
- Capture on push (same cycle that pc_addr is presented):
  - If pc[1:0] != 0: entry = {pc, NOP_INSTR, exc=1, code=0 (misaligned), val=pc}. Misalignment takes priority over imem_exc_en.
  - Else if imem_exc_en: entry = {pc, NOP_INSTR, 1, imem_exc_code, imem_exc_val}.
  - Else: entry = {pc, imem_instr, 0, 0, 0}.
  - After the push, pc ← pc + 4 (64-bit, wraps modulo 2^64).
  - If the entry carries an exception, state ← WAIT_REDIRECT and pc holds.
- No push (queue full with no pop, or state WAIT_REDIRECT): pc holds; imem inputs are ignored.
- Redirect has the highest priority, applying in any state in the cycle redirect_valid = 1:
  - Queue flushed (count ← 0, pointers ← 0); an entry popped in that same cycle is still consumed by decode.
  - pc ← redirect_pc; state ← RUN; no push that cycle.
  - First fetch from the new PC occurs the following cycle.
  - A misaligned redirect_pc yields a misaligned exception entry on that next cycle.
- Output:
  - Head of queue, combinational from queue storage.
  - out_valid = (count != 0).
  - While out_valid && !out_ready, all out_* fields hold stable.
  - Empty queue drives the reset output values.
- Latency and throughput:
  - An instruction fetched in cycle N appears at out_* in cycle N+1.
  - Sustained throughput is 1 instruction per cycle with out_ready held high.
- Pointers wrap modulo DEPTH. count is in the range 0..DEPTH, width $clog2(DEPTH)+1; simultaneous push and pop leaves count unchanged.

Decomposition:
- Shared core package: EXC_INSTR_MISALIGNED = 4'd0, EXC_INSTR_ACCESS_FAULT = 4'd1, NOP_INSTR, RESET_PC default, fetch entry struct/width constant {pc 64, instr 32, exc_en 1, code 4, val 64} = 165 bits.
- One natural sub-module: fetch_queue, a generic DEPTH-entry synchronous FIFO with flush and same-cycle push/pop when full. fetch_stage keeps the PC, FSM and capture/exception muxing.

Test Plan:
- Reset, then out_ready = 1 with imem returning 0x00100093 at PC 0 and 0x00200113 at PC 4 → pc_addr = 0, 4, 8 in consecutive cycles; out_pc = 0 then 4 one cycle later; out_valid stays 1.
- out_ready = 0 for 5 cycles (DEPTH = 2) → pc_addr advances 0→4→8 and then holds at 8; out_pc = 0 stays stable; raising out_ready drains the entries at 0 and 4 while the fetch at 8 is pushed in the same cycle.
- imem_exc_en = 1, code 1, val 0x80000 at PC 0x80000 → entry out_exc_en = 1, out_exc_code = 1, out_exc_val = 0x80000, out_instr = 0x13; pc_addr holds at 0x80000 and no further entries appear until a redirect.
- redirect_valid with redirect_pc = 0x100 while the queue holds 2 entries → next cycle out_valid = 0 and pc_addr = 0x100; the following cycle out_pc = 0x100.
- redirect_pc = 0x102 → entry with out_exc_en = 1, out_exc_code = 0, out_exc_val = 0x102, out_instr = 0x13; state is WAIT_REDIRECT.
- rst asserted while the queue is full and the state is WAIT_REDIRECT → next cycle out_valid = 0 and pc_addr = RESET_PC; fetching resumes from RESET_PC.
